// File: rtl/data_mem_arbiter_pkg.sv
// Shared encodings for the Data_Memory arbiter: FSM states and access owner.
package data_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_e;

    typedef enum logic {
        OWNER_CORE = 1'b0,
        OWNER_LDR  = 1'b1
    } owner_e;

endpackage

// File: rtl/data_mem_arbiter_rr.sv
// Combinational 2-way winner pick: loader lock first, then sole requester,
// then the round-robin pointer when both ask.
module rr_arbiter_2
    import data_mem_arbiter_pkg::*;
(
    input  logic   req_core_i,
    input  logic   req_ldr_i,
    input  logic   lock_i,
    input  owner_e ptr_i,
    output logic   valid_o,
    output owner_e winner_o
);

    always_comb begin
        valid_o  = req_core_i | req_ldr_i;
        winner_o = OWNER_CORE;
        if (lock_i && req_ldr_i) begin
            winner_o = OWNER_LDR;
        end else if (req_core_i && !req_ldr_i) begin
            winner_o = OWNER_CORE;
        end else if (req_ldr_i && !req_core_i) begin
            winner_o = OWNER_LDR;
        end else begin
            winner_o = ptr_i;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port Data_Memory between the core load/store path and the
// loader; every access runs IDLE -> ACCESS -> ACK.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Core_Req_i,
    input  logic                  Core_We_i,
    input  logic [ADDR_WIDTH-1:0] Core_Addr_i,
    input  logic [DATA_WIDTH-1:0] Core_Wdata_i,
    output logic                  Core_Ack_o,
    output logic                  Core_Stall_o,
    input  logic                  Ldr_Req_i,
    input  logic                  Ldr_We_i,
    input  logic                  Ldr_Lock_i,
    input  logic [ADDR_WIDTH-1:0] Ldr_Addr_i,
    input  logic [DATA_WIDTH-1:0] Ldr_Wdata_i,
    output logic                  Ldr_Ack_o,
    output logic [DATA_WIDTH-1:0] Rdata_o,
    output logic                  Mem_Read_o,
    output logic                  Mem_Write_o,
    output logic [ADDR_WIDTH-1:0] Mem_Addr_o,
    output logic [DATA_WIDTH-1:0] Mem_Wdata_o,
    input  logic [DATA_WIDTH-1:0] Mem_Rdata_i
);

    state_e                state_q, state_d;
    owner_e                ptr_q, ptr_d;
    owner_e                owner_q, owner_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic   arb_valid;
    owner_e arb_winner;

    rr_arbiter_2 u_rr_arbiter_2 (
        .req_core_i (Core_Req_i),
        .req_ldr_i  (Ldr_Req_i),
        .lock_i     (Ldr_Lock_i),
        .ptr_i      (ptr_q),
        .valid_o    (arb_valid),
        .winner_o   (arb_winner)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= OWNER_CORE;
            owner_q <= OWNER_CORE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        Mem_Read_o  = 1'b0;
        Mem_Write_o = 1'b0;
        Mem_Addr_o  = '0;
        Mem_Wdata_o = '0;
        Core_Ack_o  = 1'b0;
        Ldr_Ack_o   = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    owner_d = arb_winner;
                    if (arb_winner == OWNER_LDR) begin
                        we_d    = Ldr_We_i;
                        addr_d  = Ldr_Addr_i;
                        wdata_d = Ldr_Wdata_i;
                    end else begin
                        we_d    = Core_We_i;
                        addr_d  = Core_Addr_i;
                        wdata_d = Core_Wdata_i;
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // Memory sees only the command latched in IDLE, never live inputs.
                Mem_Read_o  = ~we_q;
                Mem_Write_o = we_q;
                Mem_Addr_o  = addr_q;
                Mem_Wdata_o = wdata_q;
                if (!we_q) begin
                    rdata_d = Mem_Rdata_i;
                end
                ptr_d   = (owner_q == OWNER_CORE) ? OWNER_LDR : OWNER_CORE;
                state_d = ACK;
            end
            ACK: begin
                // An access interrupted by reset is never acknowledged.
                Core_Ack_o = (owner_q == OWNER_CORE) && !reset;
                Ldr_Ack_o  = (owner_q == OWNER_LDR) && !reset;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign Core_Stall_o = Core_Req_i & ~Core_Ack_o;
    assign Rdata_o      = rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed checks for reset/pointer behaviour, then randomized two-port traffic
// scored against a transaction-level arbiter model.
module tb_data_mem_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          Core_Req_i, Core_We_i, Core_Ack_o, Core_Stall_o;
    logic [AW-1:0] Core_Addr_i;
    logic [DW-1:0] Core_Wdata_i;
    logic          Ldr_Req_i, Ldr_We_i, Ldr_Lock_i, Ldr_Ack_o;
    logic [AW-1:0] Ldr_Addr_i;
    logic [DW-1:0] Ldr_Wdata_i;
    logic [DW-1:0] Rdata_o;
    logic          Mem_Read_o, Mem_Write_o;
    logic [AW-1:0] Mem_Addr_o;
    logic [DW-1:0] Mem_Wdata_o, Mem_Rdata_i;

    always #5 clk = ~clk;

    data_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .Core_Req_i   (Core_Req_i),
        .Core_We_i    (Core_We_i),
        .Core_Addr_i  (Core_Addr_i),
        .Core_Wdata_i (Core_Wdata_i),
        .Core_Ack_o   (Core_Ack_o),
        .Core_Stall_o (Core_Stall_o),
        .Ldr_Req_i    (Ldr_Req_i),
        .Ldr_We_i     (Ldr_We_i),
        .Ldr_Lock_i   (Ldr_Lock_i),
        .Ldr_Addr_i   (Ldr_Addr_i),
        .Ldr_Wdata_i  (Ldr_Wdata_i),
        .Ldr_Ack_o    (Ldr_Ack_o),
        .Rdata_o      (Rdata_o),
        .Mem_Read_o   (Mem_Read_o),
        .Mem_Write_o  (Mem_Write_o),
        .Mem_Addr_o   (Mem_Addr_o),
        .Mem_Wdata_o  (Mem_Wdata_o),
        .Mem_Rdata_i  (Mem_Rdata_i)
    );

    // Behavioural Data_Memory: 64 words, combinational read.
    logic [31:0] mem [0:63];
    logic [31:0] ref_mem [0:63];
    assign Mem_Rdata_i = mem[Mem_Addr_o[7:2]];
    always @(posedge clk) if (Mem_Write_o) mem[Mem_Addr_o[7:2]] <= Mem_Wdata_o;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic        owner;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_cyc;
    } item_t;

    item_t sbq[$];
    bit    mon_en = 1'b0;

    // Monitor: compares memory strobes, acks, read data and stall to the queue head.
    always @(negedge clk) begin : monitor
        bit    exp_strobe;
        bit    exp_ack;
        item_t it;
        it = '{owner: 1'b0, we: 1'b0, addr: '0, wdata: '0, rdata: '0, ack_cyc: 0};
        if (mon_en) begin
            exp_strobe = (sbq.size() > 0) && (sbq[0].ack_cyc == cyc + 1);
            exp_ack    = (sbq.size() > 0) && (sbq[0].ack_cyc == cyc);
            if (sbq.size() > 0) it = sbq[0];
            if (exp_strobe || Mem_Read_o || Mem_Write_o) begin
                check("mem_read", {31'b0, Mem_Read_o}, {31'b0, exp_strobe && !it.we});
                check("mem_write", {31'b0, Mem_Write_o}, {31'b0, exp_strobe && it.we});
                if (exp_strobe) begin
                    check("mem_addr", Mem_Addr_o, it.addr);
                    if (it.we) check("mem_wdata", Mem_Wdata_o, it.wdata);
                end
            end
            if (exp_ack || Core_Ack_o || Ldr_Ack_o) begin
                check("core_ack", {31'b0, Core_Ack_o}, {31'b0, exp_ack && it.owner == 1'b0});
                check("ldr_ack", {31'b0, Ldr_Ack_o}, {31'b0, exp_ack && it.owner == 1'b1});
                if (exp_ack && !it.we) check("rdata", Rdata_o, it.rdata);
                if (exp_ack) sbq.delete(0);
            end
            check("core_stall", {31'b0, Core_Stall_o},
                  {31'b0, Core_Req_i && !(exp_ack && it.owner == 1'b0)});
        end
    end

    // Requester state for the random phase, index 0 = core, 1 = loader.
    bit          p_act  [2];
    bit          p_infl [2];
    int          p_hold [2];
    logic        p_we   [2];
    logic [31:0] p_ad   [2];
    logic [31:0] p_wd   [2];
    bit          lock;
    bit          pref;
    int          busy;

    task automatic drive_ports();
        Core_Req_i   = p_act[0];
        Core_We_i    = p_we[0];
        Core_Addr_i  = p_ad[0];
        Core_Wdata_i = p_wd[0];
        Ldr_Req_i    = p_act[1];
        Ldr_We_i     = p_we[1];
        Ldr_Addr_i   = p_ad[1];
        Ldr_Wdata_i  = p_wd[1];
        Ldr_Lock_i   = lock;
    endtask

    // Transaction-level arbiter: one grant per 3 cycles, decided only when free.
    task automatic model_step(input int c);
        int    w;
        item_t it;
        if (busy > 0) begin
            busy--;
        end else if (p_act[0] || p_act[1]) begin
            if (lock && p_act[1])       w = 1;
            else if (!p_act[1])         w = 0;
            else if (!p_act[0])         w = 1;
            else                        w = int'(pref);
            it.owner   = w[0];
            it.we      = p_we[w];
            it.addr    = p_ad[w];
            it.wdata   = p_wd[w];
            it.rdata   = ref_mem[p_ad[w][7:2]];
            it.ack_cyc = c + 2;
            if (p_we[w]) ref_mem[p_ad[w][7:2]] = p_wd[w];
            sbq.push_back(it);
            pref      = (w == 0);
            busy      = 2;
            p_infl[w] = 1'b1;
            p_hold[w] = c + 2;
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 ^ (i * 32'h0101_0101);
        mem[4] = 32'hDEAD_BEEF;
        reset = 1'b1;
        lock  = 1'b0;
        for (int p = 0; p < 2; p++) begin
            p_act[p] = 0; p_infl[p] = 0; p_hold[p] = 0;
            p_we[p] = 0; p_ad[p] = '0; p_wd[p] = '0;
        end
        drive_ports();
        repeat (3) @(negedge clk);
        check("rst_core_ack", {31'b0, Core_Ack_o}, 32'd0);
        check("rst_ldr_ack", {31'b0, Ldr_Ack_o}, 32'd0);
        check("rst_rdata", Rdata_o, 32'd0);
        check("rst_mem_rd", {31'b0, Mem_Read_o}, 32'd0);
        check("rst_mem_wr", {31'b0, Mem_Write_o}, 32'd0);
        check("rst_mem_addr", Mem_Addr_o, 32'd0);
        check("rst_stall", {31'b0, Core_Stall_o}, 32'd0);

        // Reset asserted during the ACCESS cycle of a core write.
        @(posedge clk); #1;
        reset = 1'b0;
        Core_Req_i = 1'b1; Core_We_i = 1'b1;
        Core_Addr_i = 32'h40; Core_Wdata_i = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        @(negedge clk);
        check("racc_mem_wr", {31'b0, Mem_Write_o}, 32'd1);
        check("racc_stall", {31'b0, Core_Stall_o}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rpost_mem_wr", {31'b0, Mem_Write_o}, 32'd0);
        check("rpost_mem_rd", {31'b0, Mem_Read_o}, 32'd0);
        check("rpost_core_ack", {31'b0, Core_Ack_o}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        Core_Req_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rpost_no_ack", {30'b0, Core_Ack_o, Ldr_Ack_o}, 32'd0);
            check("rpost_no_strobe", {30'b0, Mem_Read_o, Mem_Write_o}, 32'd0);
        end

        // Both request after reset: pointer 0 means core first, then loader.
        @(posedge clk); #1;
        Core_Req_i = 1'b1; Core_We_i = 1'b0; Core_Addr_i = 32'h10;
        Ldr_Req_i = 1'b1; Ldr_We_i = 1'b1; Ldr_Addr_i = 32'h20; Ldr_Wdata_i = 32'h1234_5678;
        @(negedge clk);
        @(negedge clk);
        check("c_acc_rd", {31'b0, Mem_Read_o}, 32'd1);
        check("c_acc_wr", {31'b0, Mem_Write_o}, 32'd0);
        check("c_acc_addr", Mem_Addr_o, 32'h10);
        check("c_acc_stall", {31'b0, Core_Stall_o}, 32'd1);
        @(negedge clk);
        check("c_ack", {31'b0, Core_Ack_o}, 32'd1);
        check("c_ack_ldr", {31'b0, Ldr_Ack_o}, 32'd0);
        check("c_rdata", Rdata_o, 32'hDEAD_BEEF);
        check("c_ack_stall", {31'b0, Core_Stall_o}, 32'd0);
        @(posedge clk); #1;
        Core_Req_i = 1'b0;
        @(negedge clk);
        check("l_idle_strobe", {30'b0, Mem_Read_o, Mem_Write_o}, 32'd0);
        @(negedge clk);
        check("l_acc_wr", {31'b0, Mem_Write_o}, 32'd1);
        check("l_acc_addr", Mem_Addr_o, 32'h20);
        check("l_acc_wdata", Mem_Wdata_o, 32'h1234_5678);
        @(posedge clk); #1;
        Ldr_Req_i = 1'b0;
        @(negedge clk);
        check("l_ack", {31'b0, Ldr_Ack_o}, 32'd1);
        check("l_ack_core", {31'b0, Core_Ack_o}, 32'd0);

        // Random phase; loader went last so the pointer now prefers the core.
        @(posedge clk); #1;
        for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
        pref   = 1'b0;
        busy   = 0;
        mon_en = 1'b1;
        for (int n = 0; n < 900; n++) begin
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                if (p_infl[p]) begin
                    if (cyc >= p_hold[p]) begin
                        p_infl[p] = 1'b0;
                        p_act[p]  = 1'b0;
                    end else if ($urandom_range(0, 3) == 0) begin
                        // Post-sample withdrawal and scribbled inputs must not disturb the access.
                        p_act[p] = 1'b0;
                        p_we[p]  = 1'($urandom);
                        p_ad[p]  = $urandom;
                        p_wd[p]  = $urandom;
                    end
                end
                if (!p_infl[p]) begin
                    if (p_act[p]) begin
                        if ($urandom_range(0, 9) == 0) p_act[p] = 1'b0;
                    end else if ($urandom_range(0, 2) != 0) begin
                        p_act[p] = 1'b1;
                        p_we[p]  = 1'($urandom);
                        p_ad[p]  = 32'($urandom_range(0, 15)) << 2;
                        p_wd[p]  = $urandom;
                    end
                end
            end
            if ($urandom_range(0, 24) == 0) lock = ~lock;
            drive_ports();
            model_step(cyc);
        end

        @(posedge clk); #1;
        p_act[0] = 1'b0;
        p_act[1] = 1'b0;
        lock     = 1'b0;
        drive_ports();
        for (int k = 0; k < 10 && sbq.size() > 0; k++) @(negedge clk);
        @(negedge clk);
        check("drain", 32'(sbq.size()), 32'd0);
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
